// File: rtl/accum_seq_ctrl.sv
// Integrate-and-dump sequencer for an external registered accumulator:
// clears it, streams len samples into it, waits out its latency and presents the sum.
module accum_seq_ctrl #(
  parameter int DW      = 13,
  parameter int SW      = 20,
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 128,
  parameter int ACC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  output logic [DW-1:0]    acc_a,
  output logic             acc_ce,
  output logic             acc_sclr,
  input  logic [SW-1:0]    acc_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SW-1:0]    m_data,
  output logic             busy,
  output logic             err
);

  localparam int LW = $clog2(ACC_LAT + 2);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, eff_len;
  logic [LW-1:0]    lat_cnt;
  logic             lat_done;

  assign lat_done = (lat_cnt == LW'(ACC_LAT));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    acc_ce   = 1'b0;
    acc_sclr = 1'b0;
    m_valid  = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (len == '0) err = 1'b1;
        else           state_nx = CLEAR;
      end
      CLEAR: begin
        acc_sclr = 1'b1;
        acc_ce   = 1'b1;
        state_nx = ACCUM;
      end
      ACCUM: begin
        s_ready = 1'b1;
        acc_ce  = s_valid;
        if (s_valid && count == eff_len - CNT_W'(1)) state_nx = DRAIN;
      end
      DRAIN: if (lat_done) state_nx = DONE;
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over accept and handshake; the clear also flushes any partial sum.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      s_ready  = 1'b0;
      acc_ce   = 1'b1;
      acc_sclr = 1'b1;
      m_valid  = 1'b0;
    end
    acc_a = (acc_ce && !acc_sclr) ? s_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      eff_len <= '0;
      lat_cnt <= '0;
      m_data  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && len != '0)
        eff_len <= (len > MAX_L) ? MAX_L : len;
      if (state == CLEAR)             count <= '0;
      else if (acc_ce && !acc_sclr)   count <= count + CNT_W'(1);
      // lat_cnt counts DRAIN cycles; capture happens ACC_LAT+1 edges after the last accept.
      if (state != DRAIN)             lat_cnt <= '0;
      else if (!lat_done)             lat_cnt <= lat_cnt + LW'(1);
      if (state == DRAIN && lat_done && !abort)
        m_data <= acc_y;
    end
  end

endmodule
